wb_stage: RTL and testbench
===========================

# wb_stage

Write-back stage of the five-stage NPC core, directly downstream of the memory-access stage. Accepts one retired instruction per valid/ready handshake, selects write-back data (load data or execute result), and updates the 32×32 integer register file and the four machine-mode CSRs. Provides bypassed register and CSR read ports to decode/execute, a commit trace for the simulator, an instret counter, and the `ebreak` halt.

## Interface

**Parameters**
- `RESET_MSTATUS`, default 32'h0000_1800: reset value of mstatus.
- `EBREAK_INST`, default 32'h0010_0073: encoding that triggers halt.

**Ports** (clock and reset first)
- `clk` in 1: clock.
- `rst_n` in 1: synchronous, active-low reset.
- `valid_last` in 1: memory stage holds a valid instruction.
- `ready_last` out 1: stage accepts this cycle.
- `pc` in 32: instruction address.
- `inst` in 32: instruction word.
- `R_wen` in 1: write GPR `rd`.
- `rd` in 5: destination register.
- `mem_ren` in 1: instruction was a load; select `MEM_Rdata`.
- `MEM_Rdata` in 32: extended load data.
- `Ex_result` in 32: ALU/CSR-old-value result.
- `csr_wen` in 4: CSR write enables (see Operation).
- `csrs` in 32: CSR write value.
- `jump_flag` in 1: instruction redirected the PC.
- `rs1_addr` in 5, `rs2_addr` in 5: GPR read addresses.
- `rs1_data` out 32, `rs2_data` out 32: bypassed GPR read data.
- `csr_raddr` in 12: CSR read address.
- `csr_rdata` out 32: bypassed CSR read data.
- `mtvec_o` out 32, `mepc_o` out 32: current mtvec and mepc, bypassed.
- `commit_valid` out 1: one instruction retires this cycle.
- `commit_pc` out 32, `commit_inst` out 32, `commit_jump` out 1: commit trace.
- `instret` out 64: retired-instruction count.
- `halt` out 1: ebreak retired; sticky.
- `halt_code` out 32: x10 value at halt.

## Operation

- Holding register: on `valid_last & ready_last`, latch pc, inst, R_wen, rd, mem_ren, wb data = `mem_ren ? MEM_Rdata : Ex_result`, csr_wen, csrs, jump_flag; set `wb_valid`=1. Otherwise `wb_valid`=0.
- GPR: 32×32 array. While `wb_valid & R_wen_q & rd_q!=0`, write wb data at the next edge. x0 always reads 0 and is never written.
- CSR map: mstatus 0x300, mtvec 0x305, mepc 0x341, mcause 0x342; any other address reads 0.
- `csr_wen_q` encoding when `wb_valid`:
  - 4'b1100 (ecall): mepc←pc_q, mcause←32'd11.
  - Otherwise: bit0 writes mstatus, bit1 mtvec, bit2 mepc, bit3 mcause, each ←csrs_q. Multiple bits may be set.
- Bypass: GPR and CSR reads return the in-flight `wb_valid` write value when the address matches; otherwise the array value. GPR bypass never applies to x0.
- Commit: `commit_valid`=`wb_valid`; `commit_pc`/`commit_inst`/`commit_jump` are the held values. `instret` increments by 1 at each edge where `wb_valid`=1 and wraps modulo 2^64.
- Halt FSM has two states, RUN and HALT.
  - RUN→HALT at the edge where `wb_valid & inst_q==EBREAK_INST`. The ebreak itself commits and counts.
  - `halt_code` captures the bypassed x10 value on that edge.
  - HALT is left only by reset.
- `ready_last`=1 in RUN, 0 in HALT.

## Timing

- Reset values:
  - `ready_last`=1, `wb_valid`/`commit_valid`=0, `halt`=0, `halt_code`=0, `instret`=0.
  - All GPRs 0; mstatus=`RESET_MSTATUS`; mtvec, mepc, mcause 0.
  - Commit trace registers 0.
- Latency:
  - Handshake at edge N → `commit_valid` high during cycle N..N+1.
  - Architectural GPR/CSR update at edge N+1.
  - Bypass makes the value visible on read ports during cycle N..N+1.
- Back-to-back: one instruction per cycle with no bubble. Consecutive writes to the same rd resolve in order.
- Halt: `halt` rises the cycle after the ebreak edge; `ready_last` falls at the same time. No further handshakes occur, and upstream must hold.
- Reset mid-operation: at the reset edge, a pending `wb_valid` write is discarded and nothing is committed.
- `valid_last`=0 with `ready_last`=1: no state change; `wb_valid` deasserts next cycle.

## Test plan

- Reset, then read all 32 GPRs, csr 0x300, and `instret`. Expect 0 everywhere except mstatus=0x1800; `ready_last`=1.
- ALU write: rd=5, Ex_result=0x1234, mem_ren=0. Expect `rs1_data`(5)=0x1234 in the commit cycle via bypass and after the edge from the array. Then rd=0 with 0xFFFF: x0 stays 0.
- Load select: mem_ren=1, MEM_Rdata=0xDEADBEEF, Ex_result=0x80000010, rd=7. Expect x7=0xDEADBEEF. Two back-to-back writes to x7 (1, then 2): final value 2, and `instret` +2.
- CSR: csr_wen=0010 with csrs=0x80000100 gives mtvec_o=0x80000100. Ecall at pc=0x80000040 with csr_wen=1100 gives mepc=0x80000040 and mcause=11. Read 0x7C0 returns 0.
- Halt: x10=42, then ebreak at pc=0x80000080. Expect `commit_valid` for the ebreak, `halt`=1 and `halt_code`=42 next cycle, `ready_last`=0 thereafter, and `instret` frozen. Reset clears all of it.
- Wrap: preload `instret` to 2^64−1 (force), commit one instruction. Expect 0.

Source files
------------

// File: rtl/wb_stage.sv
// Write-back stage: holds one retired instruction, updates the GPR file and machine CSRs,
// and provides bypassed read ports, a commit trace, instret and the ebreak halt.
module wb_stage #(
    parameter logic [31:0] RESET_MSTATUS = 32'h0000_1800,
    parameter logic [31:0] EBREAK_INST   = 32'h0010_0073
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_last,
    output logic        ready_last,
    input  logic [31:0] pc,
    input  logic [31:0] inst,
    input  logic        R_wen,
    input  logic [4:0]  rd,
    input  logic        mem_ren,
    input  logic [31:0] MEM_Rdata,
    input  logic [31:0] Ex_result,
    input  logic [3:0]  csr_wen,
    input  logic [31:0] csrs,
    input  logic        jump_flag,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    output logic [31:0] rs1_data,
    output logic [31:0] rs2_data,
    input  logic [11:0] csr_raddr,
    output logic [31:0] csr_rdata,
    output logic [31:0] mtvec_o,
    output logic [31:0] mepc_o,
    output logic        commit_valid,
    output logic [31:0] commit_pc,
    output logic [31:0] commit_inst,
    output logic        commit_jump,
    output logic [63:0] instret,
    output logic        halt,
    output logic [31:0] halt_code
);

    typedef enum logic {RUN, HALT} state_t;

    state_t      state_q, state_d;
    logic        wb_valid;
    logic [31:0] pc_q, inst_q, wb_data_q, csrs_q;
    logic        r_wen_q, jump_q;
    logic [4:0]  rd_q;
    logic [3:0]  csr_wen_q;
    logic [31:0] gpr [32];
    logic        gpr_we;
    logic [31:0] x10_byp;
    logic [31:0] mstatus_q, mtvec_q, mepc_q, mcause_q;
    logic [31:0] mstatus_d, mtvec_d, mepc_d, mcause_d;
    logic [63:0] instret_q;
    logic [31:0] halt_code_q;

    assign ready_last = (state_q == RUN);

    // Load data is selected here so the held word is already the write-back value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb_valid  <= 1'b0;
            pc_q      <= '0;
            inst_q    <= '0;
            r_wen_q   <= 1'b0;
            rd_q      <= '0;
            wb_data_q <= '0;
            csr_wen_q <= '0;
            csrs_q    <= '0;
            jump_q    <= 1'b0;
        end else if (valid_last && ready_last) begin
            wb_valid  <= 1'b1;
            pc_q      <= pc;
            inst_q    <= inst;
            r_wen_q   <= R_wen;
            rd_q      <= rd;
            wb_data_q <= mem_ren ? MEM_Rdata : Ex_result;
            csr_wen_q <= csr_wen;
            csrs_q    <= csrs;
            jump_q    <= jump_flag;
        end else begin
            wb_valid  <= 1'b0;
        end
    end

    assign gpr_we = wb_valid && r_wen_q && (rd_q != 5'd0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) gpr[i] <= '0;
        end else if (gpr_we) begin
            gpr[rd_q] <= wb_data_q;
        end
    end

    assign rs1_data = (rs1_addr == 5'd0) ? 32'd0 :
                      (gpr_we && rd_q == rs1_addr) ? wb_data_q : gpr[rs1_addr];
    assign rs2_data = (rs2_addr == 5'd0) ? 32'd0 :
                      (gpr_we && rd_q == rs2_addr) ? wb_data_q : gpr[rs2_addr];
    assign x10_byp  = (gpr_we && rd_q == 5'd10) ? wb_data_q : gpr[10];

    // The next-state CSR values double as the bypassed read values.
    always_comb begin
        mstatus_d = mstatus_q;
        mtvec_d   = mtvec_q;
        mepc_d    = mepc_q;
        mcause_d  = mcause_q;
        if (wb_valid) begin
            if (csr_wen_q == 4'b1100) begin
                mepc_d   = pc_q;
                mcause_d = 32'd11;
            end else begin
                if (csr_wen_q[0]) mstatus_d = csrs_q;
                if (csr_wen_q[1]) mtvec_d   = csrs_q;
                if (csr_wen_q[2]) mepc_d    = csrs_q;
                if (csr_wen_q[3]) mcause_d  = csrs_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mstatus_q <= RESET_MSTATUS;
            mtvec_q   <= '0;
            mepc_q    <= '0;
            mcause_q  <= '0;
        end else begin
            mstatus_q <= mstatus_d;
            mtvec_q   <= mtvec_d;
            mepc_q    <= mepc_d;
            mcause_q  <= mcause_d;
        end
    end

    always_comb begin
        csr_rdata = 32'd0;
        case (csr_raddr)
            12'h300: csr_rdata = mstatus_d;
            12'h305: csr_rdata = mtvec_d;
            12'h341: csr_rdata = mepc_d;
            12'h342: csr_rdata = mcause_d;
            default: csr_rdata = 32'd0;
        endcase
    end

    assign mtvec_o = mtvec_d;
    assign mepc_o  = mepc_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instret_q <= '0;
        end else if (wb_valid) begin
            instret_q <= instret_q + 64'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == RUN && wb_valid && inst_q == EBREAK_INST) state_d = HALT;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= RUN;
            halt_code_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == RUN && state_d == HALT) halt_code_q <= x10_byp;
        end
    end

    assign commit_valid = wb_valid;
    assign commit_pc    = pc_q;
    assign commit_inst  = inst_q;
    assign commit_jump  = jump_q;
    assign instret      = instret_q;
    assign halt         = (state_q == HALT);
    assign halt_code    = halt_code_q;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: directed retirements, commit trace checked by a monitor,
// register/CSR/instret/halt state checked from the stimulus thread.
module tb_wb_stage;

    logic        clk, rst_n, valid_last, ready_last;
    logic [31:0] pc, inst, MEM_Rdata, Ex_result, csrs;
    logic        R_wen, mem_ren, jump_flag;
    logic [4:0]  rd, rs1_addr, rs2_addr;
    logic [3:0]  csr_wen;
    logic [31:0] rs1_data, rs2_data, csr_rdata, mtvec_o, mepc_o;
    logic [11:0] csr_raddr;
    logic        commit_valid, commit_jump, halt;
    logic [31:0] commit_pc, commit_inst, halt_code;
    logic [63:0] instret;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        jump;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          passes = 0;
    logic [63:0] exp_instret = '0;

    wb_stage dut (
        .clk(clk), .rst_n(rst_n), .valid_last(valid_last), .ready_last(ready_last),
        .pc(pc), .inst(inst), .R_wen(R_wen), .rd(rd), .mem_ren(mem_ren),
        .MEM_Rdata(MEM_Rdata), .Ex_result(Ex_result), .csr_wen(csr_wen), .csrs(csrs),
        .jump_flag(jump_flag), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .csr_raddr(csr_raddr),
        .csr_rdata(csr_rdata), .mtvec_o(mtvec_o), .mepc_o(mepc_o),
        .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_inst(commit_inst),
        .commit_jump(commit_jump), .instret(instret), .halt(halt), .halt_code(halt_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act === expv) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    endtask

    // Drives one instruction at a negedge, queues its commit trace, returns in its commit cycle.
    task automatic applyStimulus(input logic [31:0] p, input logic [31:0] i, input logic w,
                                 input logic [4:0] d, input logic mr, input logic [31:0] md,
                                 input logic [31:0] ex, input logic [3:0] cw,
                                 input logic [31:0] cs, input logic j);
        pc = p; inst = i; R_wen = w; rd = d; mem_ren = mr; MEM_Rdata = md;
        Ex_result = ex; csr_wen = cw; csrs = cs; jump_flag = j;
        valid_last = 1'b1;
        exp_q.push_back('{pc: p, inst: i, jump: j});
        exp_instret = exp_instret + 64'd1;
        @(negedge clk);
        valid_last = 1'b0;
    endtask

    task automatic aluOp(input logic [31:0] p, input logic [4:0] d, input logic [31:0] v);
        applyStimulus(p, 32'h0000_0013, 1'b1, d, 1'b0, 32'h0, v, 4'b0000, 32'h0, 1'b0);
    endtask

    task automatic readGpr(input string name, input logic [4:0] a, input logic [31:0] expv);
        rs1_addr = a;
        #1;
        checkOutput(name, {32'd0, rs1_data}, {32'd0, expv});
    endtask

    task automatic readCsr(input string name, input logic [11:0] a, input logic [31:0] expv);
        csr_raddr = a;
        #1;
        checkOutput(name, {32'd0, csr_rdata}, {32'd0, expv});
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && commit_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("[TB] FAIL unexpected_commit: got pc 0x%0h, expected no commit", commit_pc);
            end else begin
                e = exp_q.pop_front();
                checkOutput("commit_pc", {32'd0, commit_pc}, {32'd0, e.pc});
                checkOutput("commit_inst", {32'd0, commit_inst}, {32'd0, e.inst});
                checkOutput("commit_jump", {63'd0, commit_jump}, {63'd0, e.jump});
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0; valid_last = 1'b0; pc = '0; inst = '0; R_wen = 1'b0; rd = '0;
        mem_ren = 1'b0; MEM_Rdata = '0; Ex_result = '0; csr_wen = '0; csrs = '0;
        jump_flag = 1'b0; rs1_addr = '0; rs2_addr = '0; csr_raddr = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        #1;
        checkOutput("reset_ready", {63'd0, ready_last}, 64'd1);
        checkOutput("reset_commit_valid", {63'd0, commit_valid}, 64'd0);
        checkOutput("reset_halt", {63'd0, halt}, 64'd0);
        checkOutput("reset_halt_code", {32'd0, halt_code}, 64'd0);
        checkOutput("reset_instret", instret, 64'd0);
        for (int r = 0; r < 16; r++) begin
            @(negedge clk);
            rs1_addr = 5'(r);
            rs2_addr = 5'(r + 16);
            #1;
            checkOutput($sformatf("reset_x%0d", r), {32'd0, rs1_data}, 64'd0);
            checkOutput($sformatf("reset_x%0d", r + 16), {32'd0, rs2_data}, 64'd0);
        end
        readCsr("reset_mstatus", 12'h300, 32'h0000_1800);
        checkOutput("reset_mtvec", {32'd0, mtvec_o}, 64'd0);
        checkOutput("reset_mepc", {32'd0, mepc_o}, 64'd0);
        @(negedge clk);

        aluOp(32'h8000_0000, 5'd5, 32'h1234);
        readGpr("x5_bypass", 5'd5, 32'h1234);
        @(negedge clk);
        readGpr("x5_array", 5'd5, 32'h1234);
        aluOp(32'h8000_0004, 5'd0, 32'hFFFF);
        readGpr("x0_bypass", 5'd0, 32'h0);
        @(negedge clk);
        readGpr("x0_array", 5'd0, 32'h0);

        applyStimulus(32'h8000_0008, 32'h0000_2383, 1'b1, 5'd7, 1'b1, 32'hDEAD_BEEF,
                      32'h8000_0010, 4'b0000, 32'h0, 1'b0);
        rs2_addr = 5'd7;
        #1 checkOutput("load_bypass", {32'd0, rs2_data}, 64'hDEAD_BEEF);
        @(negedge clk);
        #1 checkOutput("load_array", {32'd0, rs2_data}, 64'hDEAD_BEEF);
        applyStimulus(32'h8000_000C, 32'h0010_0393, 1'b1, 5'd7, 1'b0, 32'h0, 32'd1,
                      4'b0000, 32'h0, 1'b1);
        aluOp(32'h8000_0010, 5'd7, 32'd2);
        #1 checkOutput("b2b_bypass", {32'd0, rs2_data}, 64'd2);
        @(negedge clk);
        #1 checkOutput("b2b_array", {32'd0, rs2_data}, 64'd2);
        checkOutput("instret_after_5", instret, exp_instret);

        applyStimulus(32'h8000_0014, 32'h3052_9073, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0,
                      4'b0010, 32'h8000_0100, 1'b0);
        #1 checkOutput("mtvec_bypass", {32'd0, mtvec_o}, 64'h8000_0100);
        @(negedge clk);
        readCsr("mtvec_csr", 12'h305, 32'h8000_0100);
        applyStimulus(32'h8000_0040, 32'h0000_0073, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0,
                      4'b1100, 32'h1234_5678, 1'b1);
        #1 checkOutput("ecall_mepc_bypass", {32'd0, mepc_o}, 64'h8000_0040);
        readCsr("ecall_mcause_bypass", 12'h342, 32'd11);
        @(negedge clk);
        readCsr("ecall_mepc", 12'h341, 32'h8000_0040);
        readCsr("ecall_mcause", 12'h342, 32'd11);
        readCsr("ecall_mstatus_kept", 12'h300, 32'h0000_1800);
        applyStimulus(32'h8000_0044, 32'h3412_9073, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0,
                      4'b0101, 32'h0000_0088, 1'b0);
        @(negedge clk);
        readCsr("multi_mstatus", 12'h300, 32'h0000_0088);
        readCsr("multi_mepc", 12'h341, 32'h0000_0088);
        readCsr("unmapped_7c0", 12'h7C0, 32'h0);
        @(negedge clk);

        force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
        #1 release dut.instret_q;
        exp_instret = 64'hFFFF_FFFF_FFFF_FFFF;
        #1 checkOutput("instret_preload", instret, exp_instret);
        @(negedge clk);
        aluOp(32'h8000_0048, 5'd0, 32'h0);
        @(negedge clk);
        #1 checkOutput("instret_wrap", instret, 64'd0);

        aluOp(32'h8000_007C, 5'd10, 32'd42);
        applyStimulus(32'h8000_0080, 32'h0010_0073, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0,
                      4'b0000, 32'h0, 1'b0);
        #1 checkOutput("halt_during_commit", {63'd0, halt}, 64'd0);
        @(negedge clk);
        #1;
        checkOutput("halt_set", {63'd0, halt}, 64'd1);
        checkOutput("halt_code", {32'd0, halt_code}, 64'd42);
        checkOutput("halt_ready", {63'd0, ready_last}, 64'd0);
        checkOutput("halt_instret", instret, exp_instret);
        pc = 32'h8000_0084; inst = 32'h0000_0013; R_wen = 1'b1; rd = 5'd11;
        Ex_result = 32'd99; mem_ren = 1'b0; csr_wen = 4'b0000; valid_last = 1'b1;
        repeat (3) @(negedge clk);
        valid_last = 1'b0;
        readGpr("halt_no_write", 5'd11, 32'h0);
        checkOutput("halt_instret_frozen", instret, exp_instret);
        checkOutput("halt_sticky", {63'd0, halt}, 64'd1);

        @(negedge clk);
        rst_n = 1'b0;
        exp_instret = '0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("rst2_halt", {63'd0, halt}, 64'd0);
        checkOutput("rst2_ready", {63'd0, ready_last}, 64'd1);
        checkOutput("rst2_halt_code", {32'd0, halt_code}, 64'd0);
        checkOutput("rst2_instret", instret, 64'd0);
        checkOutput("rst2_mtvec", {32'd0, mtvec_o}, 64'd0);
        readGpr("rst2_x10", 5'd10, 32'h0);
        readCsr("rst2_mstatus", 12'h300, 32'h0000_1800);
        @(negedge clk);

        aluOp(32'h8000_0000, 5'd9, 32'h5555_AAAA);
        #1 rst_n = 1'b0;
        exp_instret = '0;
        @(negedge clk);
        rst_n = 1'b1;
        readGpr("midrst_x9", 5'd9, 32'h0);
        checkOutput("midrst_instret", instret, 64'd0);
        checkOutput("midrst_commit_valid", {63'd0, commit_valid}, 64'd0);
        @(negedge clk);

        checkOutput("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
